axi_grid_xni_link_arb: RTL and testbench

Egress link arbiter for the AXI grid network interface. It shares one outbound grid link between NUM_REQ flit sources, typically the AW, W, AR, B and R channel packetisers of one XNI. Sources are picked round-robin. The grant stays locked to one source for a whole multi-flit packet. Sending is gated by a credit counter that mirrors the free buffer slots at the downstream router.

---
 rtl/axi_grid_xni_link_arb.sv | 83 ++++++++
 tb/tb_axi_grid_xni_link_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axi_grid_xni_link_arb.sv
// axi_grid_xni_link_arb: round-robin, packet-locked, credit-gated egress link arbiter.
// Ports: req_flit_i/req_valid_i/req_last_i/req_ready_o is the per-source flit handshake.
// link_flit_o/link_valid_o/link_last_o/link_src_o is the registered egress flit.
// credit_i/credit_cnt_o/credit_ovf_o is downstream credit tracking; locked_o means a packet holds the grant.
module axi_grid_xni_link_arb #(
  parameter int NUM_REQ = 5,
  parameter int FLIT_W  = 64,
  parameter int CREDITS = 4,
  parameter int SRC_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [FLIT_W-1:0]         link_flit_o,
  output logic                      link_valid_o,
  output logic                      link_last_o,
  output logic [SRC_W-1:0]          link_src_o,
  input  logic                      credit_i,
  output logic [CNT_W-1:0]          credit_cnt_o,
  output logic                      locked_o,
  output logic                      credit_ovf_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q;
  logic [SRC_W-1:0] rr_q, owner_q, g, g_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             found, accept;
  // Scan offsets high to low so the lowest offset from rr_q wins.
  always_comb begin
    g = owner_q;
    found = req_valid_i[owner_q];
    if (state_q == IDLE) begin
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid_i[(int'(rr_q) + i) % NUM_REQ]) begin
          g = SRC_W'((int'(rr_q) + i) % NUM_REQ);
          found = 1'b1;
        end
      end
    end
  end
  assign g_nxt        = (g == SRC_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign accept       = found && (cnt_q != '0) && !srst_i;
  assign req_ready_o  = accept ? NUM_REQ'(1) << g : '0;
  assign credit_cnt_o = cnt_q;
  assign locked_o     = (state_q == LOCKED);
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      cnt_q        <= CNT_W'(CREDITS);
      credit_ovf_o <= 1'b0;
      link_valid_o <= 1'b0;
      link_flit_o  <= '0;
      link_last_o  <= 1'b0;
      link_src_o   <= '0;
    end else begin
      link_valid_o <= accept;
      if (accept) begin
        link_flit_o <= req_flit_i[g*FLIT_W +: FLIT_W];
        link_last_o <= req_last_i[g];
        link_src_o  <= g;
        if (req_last_i[g]) begin
          state_q <= IDLE;
          rr_q    <= g_nxt;
        end else begin
          state_q <= LOCKED;
          owner_q <= g;
        end
      end
      if (accept && !credit_i) cnt_q <= cnt_q - 1'b1;
      else if (!accept && credit_i) begin
        if (cnt_q == CNT_W'(CREDITS)) credit_ovf_o <= 1'b1;
        else cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_grid_xni_link_arb.sv
// tb_axi_grid_xni_link_arb: directed vector bench for the egress link arbiter.
module tb_axi_grid_xni_link_arb;
  logic         clk = 1'b0;
  logic         srst_i = 1'b1;
  logic [319:0] req_flit_i;
  logic [4:0]   req_valid_i = '0, req_last_i = '0, req_ready_o;
  logic [63:0]  link_flit_o;
  logic         link_valid_o, link_last_o, credit_i = 1'b0, locked_o, credit_ovf_o;
  logic [2:0]   link_src_o, credit_cnt_o;
  int           total = 0, bad = 0;

  axi_grid_xni_link_arb dut (
    .clk_i(clk), .srst_i(srst_i), .req_flit_i(req_flit_i), .req_valid_i(req_valid_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .link_flit_o(link_flit_o),
    .link_valid_o(link_valid_o), .link_last_o(link_last_o), .link_src_o(link_src_o),
    .credit_i(credit_i), .credit_cnt_o(credit_cnt_o), .locked_o(locked_o),
    .credit_ovf_o(credit_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] valid, last;
    logic       credit;
    logic [4:0] ready;
    logic       lv;
    logic [2:0] src;
    logic       lst;
    logic [2:0] cnt;
    logic       locked, ovf;
  } vec_t;

  function automatic logic [63:0] flit_of(int k);
    return (k == 2) ? 64'hA5 : 64'hDEAD_0000_0000_0000 + 64'(k);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 after the edge; ready is sampled before the next edge,
  // registered outputs 1 after it.
  task automatic run(vec_t v);
    srst_i = v.rst;
    req_valid_i = v.valid;
    req_last_i = v.last;
    credit_i = v.credit;
    #1;
    chk("ready", 64'(req_ready_o), 64'(v.ready));
    @(posedge clk);
    #1;
    chk("link_valid", 64'(link_valid_o), 64'(v.lv));
    if (v.lv) begin
      chk("link_src", 64'(link_src_o), 64'(v.src));
      chk("link_last", 64'(link_last_o), 64'(v.lst));
      chk("link_flit", link_flit_o, flit_of(int'(v.src)));
    end
    chk("credit_cnt", 64'(credit_cnt_o), 64'(v.cnt));
    chk("locked", 64'(locked_o), 64'(v.locked));
    chk("credit_ovf", 64'(credit_ovf_o), 64'(v.ovf));
  endtask

  vec_t tbl[19];

  initial begin
    for (int k = 0; k < 5; k++) req_flit_i[k*64 +: 64] = flit_of(k);
    tbl = '{
      // round robin, one credit back per send
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h01, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h02, 1'b1, 3'd1, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h04, 1'b1, 3'd2, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h08, 1'b1, 3'd3, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h10, 1'b1, 3'd4, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h01, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0},
      // packet lock: source 1 three flits, source 0 waiting
      '{1'b0, 5'h03, 5'h01, 1'b1, 5'h02, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1, 1'b0},
      '{1'b0, 5'h03, 5'h01, 1'b1, 5'h02, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1, 1'b0},
      '{1'b0, 5'h03, 5'h03, 1'b1, 5'h02, 1'b1, 3'd1, 1'b1, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h01, 5'h01, 1'b1, 5'h01, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0},
      // single source 2, then accept+credit at cnt=2
      '{1'b0, 5'h04, 5'h04, 1'b0, 5'h04, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, 1'b0},
      '{1'b0, 5'h04, 5'h04, 1'b0, 5'h04, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0},
      '{1'b0, 5'h04, 5'h04, 1'b1, 5'h04, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0},
      // refill and overflow
      '{1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0},
      '{1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1},
      '{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1},
      // reset clears overflow and rr; no ready during reset
      '{1'b1, 5'h1f, 5'h1f, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0},
      '{1'b0, 5'h10, 5'h10, 1'b0, 5'h10, 1'b1, 3'd4, 1'b1, 3'd3, 1'b0, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'h0);
    chk("rst_link_valid", 64'(link_valid_o), 64'h0);
    chk("rst_link_flit", link_flit_o, 64'h0);
    chk("rst_link_last", 64'(link_last_o), 64'h0);
    chk("rst_link_src", 64'(link_src_o), 64'h0);
    chk("rst_credit_cnt", 64'(credit_cnt_o), 64'd4);
    chk("rst_locked", 64'(locked_o), 64'h0);
    chk("rst_ovf", 64'(credit_ovf_o), 64'h0);
    for (int i = 0; i < 19; i++) run(tbl[i]);
    // credit stall: 6-flit packet from source 0 with no credits returned
    run('{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      run('{1'b0, 5'h01, 5'h00, 1'b0, 5'h01, 1'b1, 3'd0, 1'b0, 3'(3 - i), 1'b1, 1'b0});
    run('{1'b0, 5'h01, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0});
    run('{1'b0, 5'h01, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0});
    run('{1'b0, 5'h01, 5'h00, 1'b0, 5'h01, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0});
    run('{1'b0, 5'h01, 5'h01, 1'b1, 5'h00, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0});
    run('{1'b0, 5'h01, 5'h01, 1'b0, 5'h01, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0});
    // reset after the 2nd flit of a 4-flit packet from source 3
    run('{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0});
    run('{1'b0, 5'h08, 5'h00, 1'b0, 5'h08, 1'b1, 3'd3, 1'b0, 3'd3, 1'b1, 1'b0});
    run('{1'b0, 5'h08, 5'h00, 1'b0, 5'h08, 1'b1, 3'd3, 1'b0, 3'd2, 1'b1, 1'b0});
    run('{1'b1, 5'h0a, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0});
    run('{1'b0, 5'h0a, 5'h0a, 1'b0, 5'h02, 1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
